sp_pe_stream: RTL and testbench

Streaming sparse-row × dense-column processing element for the SpMM stage. It accepts a sparse feature row in CSR-style beats of up to `LANES` nonzeros each. Every lane multiplies its value by the weight selected by its column index; lane products are reduced in an adder tree and accumulated across beats until the row's last beat. A saturated, optionally right-shifted result is then emitted on a valid/ready output. Rows may span multiple beats, and backpressure stalls the whole pipeline without data loss.

---
 rtl/sp_pe_stream.sv | 179 +++++++++++++++++
 tb/tb_sp_pe_stream.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_pe_stream.sv
// Streaming sparse-row x dense-column processing element: per-lane gather-multiply,
// adder-tree reduction, per-row accumulation and saturated output under valid/ready backpressure.
module sp_pe_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int COL_DEPTH  = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int FRAC_BITS  = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [$clog2(LANES):0]                 nnz_i,
  input  logic                                   last_i,
  input  logic [LANES*$clog2(COL_DEPTH)-1:0]     col_idx_i,
  input  logic [LANES*DATA_WIDTH-1:0]            value_i,
  input  logic [COL_DEPTH*DATA_WIDTH-1:0]        weight_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [DATA_WIDTH-1:0]                  result_o,
  output logic                                   sat_o,
  output logic                                   err_o
);

  localparam int CW = $clog2(COL_DEPTH);
  localparam int NW = $clog2(LANES) + 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + $clog2(LANES);
  localparam int TW = 1 << CW;
  localparam logic [NW-1:0] LANES_N = NW'(LANES);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(COL_DEPTH);

  function automatic logic [ACC_WIDTH-1:0] acc_sat(input logic [ACC_WIDTH:0] s);
    return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
  endfunction

  function automatic logic out_ovf(input logic [ACC_WIDTH-1:0] a);
    logic [ACC_WIDTH-1:0] sh;
    sh = a >> FRAC_BITS;
    return |(sh >> DATA_WIDTH);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] out_sat(input logic [ACC_WIDTH-1:0] a);
    logic [ACC_WIDTH-1:0] sh;
    sh = a >> FRAC_BITS;
    return (|(sh >> DATA_WIDTH)) ? '1 : sh[DATA_WIDTH-1:0];
  endfunction

  // A held result freezes every stage, so ready depends only on the output register.
  logic stall, adv, fire;
  assign stall      = out_valid_o && !out_ready_i;
  assign adv        = !stall;
  assign in_ready_o = adv;
  assign fire       = in_valid_i && adv;

  // Weight column padded to a power of two so any index value selects a defined entry.
  logic [DATA_WIDTH-1:0] wtab [TW];
  for (genvar j = 0; j < TW; j++) begin : g_wtab
    if (j < COL_DEPTH) begin : g_real
      assign wtab[j] = weight_i[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign wtab[j] = '0;
    end
  end

  logic [NW-1:0]    nnz_eff;
  logic [PW-1:0]    prod [LANES];
  logic [LANES-1:0] bad;
  assign nnz_eff = (nnz_i > LANES_N) ? LANES_N : nnz_i;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CW-1:0]         col;
    logic [DATA_WIDTH-1:0] val;
    logic                  act, in_rng;
    assign col     = col_idx_i[k*CW +: CW];
    assign val     = value_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign act     = NW'(k) < nnz_eff;
    assign in_rng  = {1'b0, col} < DEPTH_C;
    assign bad[k]  = act && !in_rng;
    assign prod[k] = (act && in_rng) ? PW'(val) * PW'(wtab[col]) : '0;
  end

  // ---- S1: lane products ----
  logic [PW-1:0] prod_p1 [LANES];
  logic          vld_p1, last_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      err_o   <= 1'b0;
    end else if (adv) begin
      vld_p1  <= fire;
      last_p1 <= last_i;
      if (fire && |bad) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < LANES; k++) prod_p1[k] <= prod[k];
    end
  end

  logic [SW-1:0] tree_sum;
  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < LANES; k++) tree_sum = tree_sum + SW'(prod_p1[k]);
  end

  // ---- S2: exact partial sum ----
  logic [SW-1:0] psum_p2;
  logic          vld_p2, last_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (adv) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) psum_p2 <= tree_sum;
  end

  // ---- S3: row accumulation; a closing beat hands the row total to the output stage ----
  logic [ACC_WIDTH-1:0] acc, acc_next, fin_p3;
  logic [ACC_WIDTH:0]   acc_wide;
  logic                 acc_ovf, row_sat, vld_p3, fin_sat_p3;
  assign acc_wide = {1'b0, acc} + (ACC_WIDTH+1)'(psum_p2);
  assign acc_next = acc_sat(acc_wide);
  assign acc_ovf  = acc_wide[ACC_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      row_sat <= 1'b0;
      vld_p3  <= 1'b0;
    end else if (adv) begin
      vld_p3 <= vld_p2 && last_p2;
      if (vld_p2) begin
        if (last_p2) begin
          acc     <= '0;
          row_sat <= 1'b0;
        end else begin
          acc     <= acc_next;
          row_sat <= row_sat | acc_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv && vld_p2 && last_p2) begin
      fin_p3     <= acc_next;
      fin_sat_p3 <= row_sat | acc_ovf;
    end
  end

  // ---- Output register: shift, clamp, hold until consumed ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      sat_o       <= 1'b0;
    end else if (adv && vld_p3) begin
      out_valid_o <= 1'b1;
      result_o    <= out_sat(fin_p3);
      sat_o       <= fin_sat_p3 | out_ovf(fin_p3);
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sp_pe_stream.sv
// Bench for sp_pe_stream: two instances (defaults, and COL_DEPTH=6/FRAC_BITS=4) share one
// stimulus stream; results are checked against a row-level arithmetic model.
module tb_sp_pe_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, last;
  logic [2:0]  nnz;
  logic [11:0] col;
  logic [31:0] val;
  logic [63:0] wt;
  logic        rdy_a, ov_a, sat_a, err_a;
  logic        rdy_b, ov_b, sat_b, err_b;
  logic [7:0]  res_a, res_b;

  sp_pe_stream #(.DATA_WIDTH(8), .LANES(4), .COL_DEPTH(8), .ACC_WIDTH(24), .FRAC_BITS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_a), .nnz_i(nnz),
    .last_i(last), .col_idx_i(col), .value_i(val), .weight_i(wt), .out_valid_o(ov_a),
    .out_ready_i(out_ready), .result_o(res_a), .sat_o(sat_a), .err_o(err_a));

  sp_pe_stream #(.DATA_WIDTH(8), .LANES(4), .COL_DEPTH(6), .ACC_WIDTH(24), .FRAC_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_b), .nnz_i(nnz),
    .last_i(last), .col_idx_i(col), .value_i(val), .weight_i(wt[47:0]), .out_valid_o(ov_b),
    .out_ready_i(out_ready), .result_o(res_b), .sat_o(sat_b), .err_o(err_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Row-level model: index i=0 is dut_a, i=1 is dut_b.
  localparam longint MAXACC = (64'd1 << 24) - 1;
  longint acc_m [2];
  bit     rs_m  [2];
  bit     er_m  [2];
  int     exp_q0 [$];
  int     exp_q1 [$];

  function automatic longint beat_sum(input int depth, output bit bad);
    int n;
    longint s;
    bad = 0;
    s = 0;
    n = (nnz > 4) ? 4 : int'(nnz);
    for (int k = 0; k < n; k++) begin
      int c;
      c = int'(col[k*3 +: 3]);
      if (c < depth) s += longint'(val[k*8 +: 8]) * longint'(wt[c*8 +: 8]);
      else bad = 1;
    end
    return s;
  endfunction

  task automatic model_accept();
    for (int i = 0; i < 2; i++) begin
      bit bad;
      longint s, v;
      int e;
      s = beat_sum((i == 0) ? 8 : 6, bad);
      if (bad) er_m[i] = 1;
      acc_m[i] += s;
      if (acc_m[i] > MAXACC) begin acc_m[i] = MAXACC; rs_m[i] = 1; end
      if (last) begin
        v = acc_m[i] >> ((i == 0) ? 0 : 4);
        if (v > 255) begin v = 255; rs_m[i] = 1; end
        e = (int'(rs_m[i]) << 8) | int'(v);
        if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        acc_m[i] = 0;
        rs_m[i] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      acc_m = '{0, 0};
      rs_m  = '{0, 0};
      er_m  = '{0, 0};
    end else begin
      if (ov_a && out_ready) begin
        if (exp_q0.size() == 0) check("a_extra_result", ov_a, 0);
        else begin
          e = exp_q0.pop_front();
          check("a_result", res_a, e & 255);
          check("a_sat", sat_a, e >> 8);
        end
      end
      if (ov_b && out_ready) begin
        if (exp_q1.size() == 0) check("b_extra_result", ov_b, 0);
        else begin
          e = exp_q1.pop_front();
          check("b_result", res_b, e & 255);
          check("b_sat", sat_b, e >> 8);
        end
      end
      if (in_valid && rdy_a) model_accept();
    end
  end

  task automatic beat(input int n, input bit l, input int c0, c1, c2, c3,
                      input int v0, v1, v2, v3);
    in_valid = 1'b1;
    nnz  = 3'(n);
    last = l;
    col  = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    val  = {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
    @(negedge clk);
    for (int t = 0; t < 200 && !rdy_a; t++) @(negedge clk);
    if (!rdy_a) check("beat_accept_timeout", rdy_a, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int ea, input int sa, input int eb, input int sb);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ov_a) break;
    end
    check({tag, "_valid"}, ov_a, 1);
    if (ea >= 0) begin
      check({tag, "_a_res"}, res_a, ea);
      check({tag, "_a_sat"}, sat_a, sa);
    end
    if (eb >= 0) begin
      check({tag, "_b_res"}, res_b, eb);
      check({tag, "_b_sat"}, sat_b, sb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int j, input int w);
    wt[j*8 +: 8] = 8'(w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  bit rand_done;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; last = 1'b0;
    nnz = '0; col = '0; val = '0; wt = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", ov_a, 0);
    check("rst_result", res_a, 0);
    check("rst_sat", sat_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_err_b", err_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", rdy_a, 1);

    // Single-beat row and its latency
    set_w(0, 1); set_w(5, 2); set_w(7, 3);
    beat(3, 1, 0, 5, 7, 0, 2, 3, 4, 0);
    @(posedge clk); #1 check("lat_t1", ov_a, 0);
    @(posedge clk); #1 check("lat_t2", ov_a, 0);
    @(posedge clk); #1 check("lat_t3", ov_a, 1);
    wait_out("single", 20, 0, 0, 0);
    check("err_a_clean", err_a, 0);
    check("err_b_set", err_b, 1);

    // Two-beat saturating row, then a fresh small row
    wt = '0; set_w(0, 10); set_w(1, 20); set_w(2, 1);
    beat(1, 0, 0, 0, 0, 0, 10, 0, 0, 0);
    beat(1, 1, 1, 0, 0, 0, 10, 0, 0, 0);
    wait_out("two_beat", 255, 1, 18, 0);
    beat(1, 1, 2, 0, 0, 0, 7, 0, 0, 0);
    wait_out("after_sat", 7, 0, 0, 0);

    // Fractional shift and output clamp
    set_w(3, 16);
    beat(1, 1, 3, 0, 0, 0, 16, 0, 0, 0);
    wait_out("frac_16", 255, 1, 16, 0);
    set_w(0, 255); set_w(1, 255); set_w(2, 255); set_w(3, 255);
    beat(4, 1, 0, 1, 2, 3, 255, 255, 255, 255);
    wait_out("frac_max", 255, 1, 255, 1);

    // Backpressure: three rows held, then released in order
    wt = '0; set_w(0, 1);
    out_ready = 1'b0;
    beat(1, 1, 0, 0, 0, 0, 5, 0, 0, 0);
    beat(1, 1, 0, 0, 0, 0, 6, 0, 0, 0);
    beat(1, 1, 0, 0, 0, 0, 7, 0, 0, 0);
    @(posedge clk); #1;
    check("bp_valid", ov_a, 1);
    check("bp_ready_a", rdy_a, 0);
    check("bp_ready_b", rdy_b, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_res", res_a, 5);
    check("bp_hold_ready", rdy_a, 0);
    out_ready = 1'b1;
    #1 check("bp_release_ready", rdy_a, 1);
    wait_out("bp_r0", 5, 0, 0, 0);
    wait_out("bp_r1", 6, 0, 0, 0);
    wait_out("bp_r2", 7, 0, 0, 0);

    // Boundaries
    beat(0, 1, 1, 2, 3, 4, 9, 9, 9, 9);
    wait_out("nnz0", 0, 0, 0, 0);
    set_w(1, 1); set_w(2, 1); set_w(3, 1);
    beat(6, 1, 0, 1, 2, 3, 1, 1, 1, 1);
    wait_out("nnz6", 4, 0, 0, 0);
    set_w(7, 2);
    beat(2, 1, 7, 0, 0, 0, 9, 200, 0, 0);
    wait_out("bad_col", 218, 0, 12, 0);
    repeat (3) @(posedge clk);
    #1;
    check("err_b_sticky", err_b, 1);
    check("err_a_stays0", err_a, 0);

    // Reset mid-row with a held result
    out_ready = 1'b0;
    beat(1, 1, 0, 0, 0, 0, 30, 0, 0, 0);
    beat(1, 0, 0, 0, 0, 0, 50, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", ov_a, 1);
    check("pre_rst_res", res_a, 30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ov_a, 0);
    check("mid_rst_res", res_a, 0);
    check("mid_rst_sat", sat_a, 0);
    check("mid_rst_err_b", err_b, 0);
    check("mid_rst_valid_b", ov_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    check("post_rst_ready", rdy_a, 1);
    beat(1, 1, 0, 0, 0, 0, 9, 0, 0, 0);
    wait_out("post_rst", 9, 0, 0, 0);

    // Randomized traffic with random backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int v[4];
          for (int k = 0; k < 4; k++)
            v[k] = ($urandom % 3 == 0) ? int'($urandom % 256) : int'($urandom % 16);
          for (int j = 0; j < 8; j++) set_w(j, int'($urandom % 256));
          beat(int'($urandom % 8), ($urandom % 3) == 0,
               int'($urandom % 8), int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
               v[0], v[1], v[2], v[3]);
          if ($urandom % 4 == 0) begin @(posedge clk); #1; end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom % 4) != 0;
        end
      end
    join
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int t = 0; t < 100 && (exp_q0.size() != 0 || exp_q1.size() != 0); t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("drain_a", exp_q0.size(), 0);
    check("drain_b", exp_q1.size(), 0);
    check("drain_idle", ov_a, 0);
    check("final_err_a", err_a, er_m[0]);
    check("final_err_b", err_b, er_m[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
